pixel_combinator: RTL
=====================

# pixel_combinator

- Reads the per-engine result queues and reassembles their pixels into one raster-ordered stream for the video output stage.
- Each cycle it broadcasts the next wanted coordinate to every queue and captures the colour from whichever queue matches.
- It then advances the raster position and pushes the pixel, with start/end-of-frame markers, into a 2-entry output buffer with valid/ready handshake.
- It sits between the engine queues and the video sink.

## Interface
- DATA_WIDTH, 10, coordinate width
- RBG_SIZE, 24, colour width
- NUM_QUEUES, 4, number of engine queues read
- IMAGE_W, 640, pixels per line; must be ≤ 2^DATA_WIDTH − 1
- IMAGE_H, 480, lines per frame; must be ≤ 2^DATA_WIDTH − 1
- clk  in  1  single clock; falling edge used only for match/colour capture
- reset  in  1  asynchronous, active-high; clears all state on both edges' flops
- match_i  in  NUM_QUEUES  per-queue match flag (combinational in queue)
- colour_i  in  NUM_QUEUES*RBG_SIZE  per-queue colour, queue k at bits [k*RBG_SIZE +: RBG_SIZE]
- xpixel_check  out  DATA_WIDTH  wanted x, broadcast to all queues
- ypixel_check  out  DATA_WIDTH  wanted y, broadcast to all queues
- out_data  out  RBG_SIZE  pixel colour
- out_valid  out  1  out_data/out_sop/out_eop valid
- out_ready  in  1  sink accepts when out_valid && out_ready at posedge
- out_sop  out  1  pixel is (0,0)
- out_eop  out  1  pixel is (IMAGE_W−1, IMAGE_H−1)
- frame_count  out  16  frames completed, wraps
- err_multi  out  1  sticky: more than one match_i seen in one capture

## Operation
- State: raster position (cur_x, cur_y); output FIFO of 2 entries × (RBG_SIZE+2) bits; count 0..2.
- Coordinate presentation, registered at posedge:
  - If post-update count ≤ 1: check = (cur_x, cur_y).
  - Else: check = sentinel (all ones in both x and y), so no queue can match or pop.
- Capture at negedge, the same edge on which a queue pops:
  - match_q ← match_i.
  - col_q ← colour of the lowest-index set bit of match_i.
  - If popcount(match_i) > 1: set err_multi; it stays set until reset.
- Posedge when |match_q:
  - Push {col_q, sop, eop} into the FIFO; sop/eop are computed from (cur_x, cur_y).
  - Advance position: x+1; at x = IMAGE_W−1, x←0 and y+1; at y = IMAGE_H−1 with x = IMAGE_W−1, y←0 and frame_count+1.
- match_q must be ignored if it was captured while the sentinel was presented; by construction it is 0.
- FIFO push and pop:
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Push never occurs at count = 2 (the sentinel guarantees it).
- Output ports are driven from the FIFO head. out_valid = (count ≠ 0).
- A pixel that no queue ever supplies stalls the stream indefinitely. There is no timeout; that is the distributor's responsibility.

## Timing
- Reset values:
  - xpixel_check = 0, ypixel_check = 0.
  - out_valid = 0, out_data = 0, out_sop = 0, out_eop = 0.
  - frame_count = 0, err_multi = 0, match_q = 0, count = 0.
- Reset asserted mid-frame:
  - Position returns to (0,0) and the FIFO is flushed.
  - Pixels in flight are discarded.
  - The first pixel after release carries sop.
- Latency: a match at negedge N gives out_valid high after posedge N+1, half a cycle later, provided the FIFO was empty.
- The new coordinate is presented after that same posedge.
- Throughput: 1 pixel/cycle sustained while out_ready = 1.
- Backpressure:
  - With out_ready = 0, at most 2 pixels are buffered.
  - The sentinel appears on the posedge at which count becomes 2.
  - The real coordinate returns on the posedge after the first pop.
- Boundaries:
  - Line wrap (IMAGE_W−1 → 0, y+1) and frame wrap both occur in the same posedge as the push.
  - frame_count wraps 0xFFFF → 0.

## Test plan
- **Basic ordering:** 4 queues hold interleaved pixels (0,0)…(7,0), with queue k holding x ≡ k mod 4, and out_ready = 1 → out_data stream is in x order, 1 pixel/cycle, sop only on (0,0).
- **Backpressure:** out_ready = 0 from cycle 0 with all pixels available → exactly 2 pixels buffered and check = (1023,1023). Raise out_ready → remaining pixels follow with no loss or duplication.
- **Frame wrap** (IMAGE_W = 4, IMAGE_H = 2): supply 8 pixels → eop on (3,1), frame_count 0→1, next check = (0,0), next pixel carries sop.
- **Missing pixel:** omit (2,0) from all queues → output stops after (1,0) and check holds at (2,0). Supply (2,0) later → stream resumes.
- **Multi-match:** force match_i = 4'b0110 in one negedge → colour from queue 1 taken, err_multi = 1 and stays 1.
- **Reset mid-frame:** assert reset at pixel (5,1) with 2 buffered → immediately out_valid = 0 and check = (0,0); after release the first output has sop = 1 and frame_count = 0.

Source files
------------

// File: rtl/pixel_combinator.sv
// pixel_combinator: pulls pixels from the per-engine result queues in raster order
// and hands them to the video sink through a 2-deep valid/ready output buffer.
module pixel_combinator #(
    parameter int DATA_WIDTH = 10,
    parameter int RBG_SIZE   = 24,
    parameter int NUM_QUEUES = 4,
    parameter int IMAGE_W    = 640,
    parameter int IMAGE_H    = 480
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_QUEUES-1:0]          match_i,
    input  logic [NUM_QUEUES*RBG_SIZE-1:0] colour_i,
    output logic [DATA_WIDTH-1:0]          xpixel_check,
    output logic [DATA_WIDTH-1:0]          ypixel_check,
    output logic [RBG_SIZE-1:0]            out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_sop,
    output logic                           out_eop,
    output logic [15:0]                    frame_count,
    output logic                           err_multi
);
    localparam logic [DATA_WIDTH-1:0] X_LAST   = DATA_WIDTH'(IMAGE_W - 1);
    localparam logic [DATA_WIDTH-1:0] Y_LAST   = DATA_WIDTH'(IMAGE_H - 1);
    localparam logic [DATA_WIDTH-1:0] SENTINEL = '1;
    localparam int                    ENTRY_W  = RBG_SIZE + 2;

    // Lowest-index matching queue wins when several respond.
    function automatic logic [RBG_SIZE-1:0] select_colour(
        input logic [NUM_QUEUES-1:0]          m,
        input logic [NUM_QUEUES*RBG_SIZE-1:0] c
    );
        logic [RBG_SIZE-1:0] sel;
        sel = '0;
        for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
            if (m[k]) sel = c[k*RBG_SIZE +: RBG_SIZE];
        end
        return sel;
    endfunction

    function automatic logic multi_hit(input logic [NUM_QUEUES-1:0] m);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int k = 0; k < NUM_QUEUES; k++) begin
            if (m[k] && seen) multi = 1'b1;
            if (m[k]) seen = 1'b1;
        end
        return multi;
    endfunction

    logic [NUM_QUEUES-1:0] match_p0;
    logic [RBG_SIZE-1:0]   col_p0;
    logic                  vld_p0;

    logic [DATA_WIDTH-1:0] cur_x;
    logic [DATA_WIDTH-1:0] cur_y;
    logic [DATA_WIDTH-1:0] x_nxt;
    logic [DATA_WIDTH-1:0] y_nxt;
    logic                  frame_inc;
    logic                  sentinel_on;
    logic                  sop_now;
    logic                  eop_now;

    logic [ENTRY_W-1:0]    fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_cnt;
    logic [1:0]            cnt_nxt;
    logic                  pop;
    logic [ENTRY_W-1:0]    head;

    // ---- stage p0: capture on the falling edge, where the queues pop ----
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            match_p0  <= '0;
            col_p0    <= '0;
            err_multi <= 1'b0;
        end else begin
            match_p0 <= match_i;
            col_p0   <= select_colour(match_i, colour_i);
            if (multi_hit(match_i)) err_multi <= 1'b1;
        end
    end

    // A capture taken while the sentinel was on the bus is never a real pixel.
    assign sentinel_on = (xpixel_check == SENTINEL) && (ypixel_check == SENTINEL);
    assign vld_p0      = (|match_p0) && !sentinel_on;
    assign sop_now     = (cur_x == '0) && (cur_y == '0);
    assign eop_now     = (cur_x == X_LAST) && (cur_y == Y_LAST);
    assign pop         = out_valid && out_ready;

    always_comb begin
        x_nxt     = cur_x;
        y_nxt     = cur_y;
        frame_inc = 1'b0;
        if (vld_p0) begin
            if (cur_x == X_LAST) begin
                x_nxt = '0;
                if (cur_y == Y_LAST) begin
                    y_nxt     = '0;
                    frame_inc = 1'b1;
                end else begin
                    y_nxt = cur_y + 1'b1;
                end
            end else begin
                x_nxt = cur_x + 1'b1;
            end
        end
    end

    always_comb begin
        cnt_nxt = fifo_cnt;
        case ({vld_p0, pop})
            2'b10:   cnt_nxt = fifo_cnt + 1'b1;
            2'b01:   cnt_nxt = fifo_cnt - 1'b1;
            default: cnt_nxt = fifo_cnt;
        endcase
    end

    // ---- stage p1: raster advance, buffer update, next coordinate ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_x        <= '0;
            cur_y        <= '0;
            frame_count  <= '0;
            xpixel_check <= '0;
            ypixel_check <= '0;
            fifo_cnt     <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_mem[0]  <= '0;
            fifo_mem[1]  <= '0;
        end else begin
            cur_x    <= x_nxt;
            cur_y    <= y_nxt;
            fifo_cnt <= cnt_nxt;
            if (frame_inc) frame_count <= frame_count + 16'd1;
            if (vld_p0) begin
                fifo_mem[wr_ptr] <= {col_p0, sop_now, eop_now};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            // A full buffer must not be offered another pixel.
            if (cnt_nxt <= 2'd1) begin
                xpixel_check <= x_nxt;
                ypixel_check <= y_nxt;
            end else begin
                xpixel_check <= SENTINEL;
                ypixel_check <= SENTINEL;
            end
        end
    end

    assign head      = fifo_mem[rd_ptr];
    assign out_data  = head[ENTRY_W-1:2];
    assign out_sop   = head[1];
    assign out_eop   = head[0];
    assign out_valid = (fifo_cnt != 2'd0);

endmodule
